// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM: opcodes,
// state encodings, datapath select encodings, the control-word struct and a
// helper that maps a DECODE-time opcode to its first execution state.
package mips_mc_ctrl_pkg;

  // IR[31:26] opcodes the controller understands
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // The encoding is visible on the debug state port, so it is fixed
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_JR       = 4'd13,
    S_JAL      = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  // mem_to_reg selects
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // reg_dst selects
  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  // alu_src_b selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // alu_op codes handed to the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // First state after DECODE; anything unrecognised traps
  function automatic state_e decode_opcode(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_ADDI:      nxt = S_ADDI_EX;
      OP_J:         nxt = S_JUMP;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Bundle between the main control FSM and the multi-cycle datapath.
//   master : the controller (drives control word, illegal, instr_cnt, state)
//   slave  : the datapath (drives opcode, jr, mem_ready)
interface mips_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             jr;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_src;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       mem_to_reg;
  logic [1:0]       reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state;

  modport master (
    input  opcode, jr, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, illegal, instr_cnt, state
  );

  modport slave (
    output opcode, jr, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, illegal, instr_cnt, state
  );
endinterface

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs).
//   state_i     : current FSM state
//   mem_ready_i : qualifies ir_write/pc_write during FETCH only
//   ctrl_o      : datapath / memory control word
module mips_mc_outdec
  import mips_mc_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    // NOTE: zero the whole word first so every state only lists what it
    // raises, and no field can be left unassigned (no latch).
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        // IR and PC+4 commit only on the cycle the fetch completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.pc_src    = PC_SRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;   // branch target into ALUOut
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_dst    = RDST_RT;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_CMP;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_SRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      S_JR: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_SRC_RS;
      end
      S_JAL: begin
        // PC still holds the return address; the register file captures it
        // on the same edge that loads the jump target.
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PC_SRC_JUMP;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RDST_R31;
        ctrl_o.mem_to_reg = M2R_PC;
      end
      default: ctrl_o = '0;               // IDLE, TRAP
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master side of mips_mc_ctrl_if (opcode/jr/mem_ready in,
//           control word, sticky illegal flag, retired count, debug state out)
// Outputs are decoded from the state register, so an asynchronous reset
// drops every request (mem_read/mem_write included) immediately.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  mips_mc_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_opcode(bus.opcode);
      // Only lw and sw reach MEM_ADDR
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = bus.jr ? S_JR : S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_JR, S_JAL:
                  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;       // only reset leaves TRAP
      default:    state_d = S_IDLE;
    endcase
  end

  // An instruction retires when its last state hands over to FETCH; the
  // first FETCH after IDLE and FETCH stalls do not count.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                  (state_q != S_IDLE);

  // NOTE: asynchronous reset in the sensitivity list, and non-blocking
  // assignments for every register so all of them update from the
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);   // wraps naturally
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  mips_mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.illegal       = illegal_q;
  assign bus.instr_cnt     = cnt_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. A reference model expands each
// instruction class into its list of spec-defined phases, inserts memory
// stalls, and predicts the control word, debug state and retired count for
// every cycle. A narrow counter is used so that wrap-around is exercised.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 5;

  // Debug-port state numbers as published for the controller
  localparam int P_IDLE = 0,  P_FETCH = 1,  P_DECODE = 2,  P_MEM_ADDR = 3,
                 P_MEM_RD = 4, P_MEM_WB = 5, P_MEM_WR = 6,  P_EXEC = 7,
                 P_ALU_WB = 8, P_BRANCH = 9, P_JUMP = 10,   P_ADDI_EX = 11,
                 P_ADDI_WB = 12, P_JR = 13,  P_JAL = 14,    P_TRAP = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int phases[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word, packed in a fixed order of fields
  function automatic logic [17:0] exp_ctrl(input int p, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca;
    logic [1:0] pcs, m2r, rdst, srcb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, rw, srca} = '0;
    {pcs, m2r, rdst, srcb, aop} = '0;
    case (p)
      P_FETCH:   begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      P_DECODE:  srcb = 2'b11;
      P_MEM_ADDR, P_ADDI_EX: begin srca = 1; srcb = 2'b10; end
      P_MEM_RD:  begin mrd = 1; iord = 1; end
      P_MEM_WB:  begin rw = 1; m2r = 2'b01; end
      P_MEM_WR:  begin mwr = 1; iord = 1; end
      P_EXEC:    begin srca = 1; aop = 2'b10; end
      P_ALU_WB:  begin rw = 1; rdst = 2'b01; end
      P_BRANCH:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      P_JUMP:    begin pcw = 1; pcs = 2'b10; end
      P_ADDI_WB: rw = 1;
      P_JR:      begin pcw = 1; pcs = 2'b11; end
      P_JAL:     begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
      default:   ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop};
  endfunction

  function automatic logic [17:0] obs_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
            bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op};
  endfunction

  // Instruction class -> phase sequence; returns 0 for an illegal opcode
  function automatic bit build_phases(input logic [5:0] op, input logic j);
    phases = '{P_FETCH, P_DECODE};
    case (op)
      6'h00: begin phases.push_back(P_EXEC); phases.push_back(j ? P_JR : P_ALU_WB); end
      6'h23: begin phases.push_back(P_MEM_ADDR); phases.push_back(P_MEM_RD);
                   phases.push_back(P_MEM_WB); end
      6'h2B: begin phases.push_back(P_MEM_ADDR); phases.push_back(P_MEM_WR); end
      6'h04: phases.push_back(P_BRANCH);
      6'h08: begin phases.push_back(P_ADDI_EX); phases.push_back(P_ADDI_WB); end
      6'h02: phases.push_back(P_JUMP);
      6'h03: phases.push_back(P_JAL);
      default: begin phases.push_back(P_TRAP); return 1'b0; end
    endcase
    return 1'b1;
  endfunction

  // Entered at posedge+1 with the DUT expected in FETCH. fstall/mstall are
  // the cycles mem_ready stays low in FETCH and in the data access.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic j, input int fstall, input int mstall);
    bit legal;
    int idx = 0;
    int fleft = fstall;
    int mleft = mstall;
    legal = build_phases(op, j);
    // An illegal opcode stops once TRAP is reached; the trap loop takes over
    while (idx < phases.size() && !(phases[idx] == P_TRAP)) begin
      int p = phases[idx];
      bit stalled = 1'b0;
      logic mr;
      bus.opcode = (p == P_FETCH) ? 6'($urandom) : op;
      bus.jr     = (p == P_EXEC) ? j : 1'($urandom);
      if (p == P_FETCH && fleft > 0) begin stalled = 1'b1; fleft--; end
      else if ((p == P_MEM_RD || p == P_MEM_WR) && mleft > 0) begin
        stalled = 1'b1; mleft--;
      end
      if (p == P_FETCH || p == P_MEM_RD || p == P_MEM_WR) mr = !stalled;
      else mr = 1'($urandom);            // must be ignored here
      bus.mem_ready = mr;
      #1;
      check({name, ".state"},   32'(bus.state),     32'(p));
      check({name, ".ctrl"},    32'(obs_ctrl()),    32'(exp_ctrl(p, mr)));
      check({name, ".illegal"}, 32'(bus.illegal),   32'(0));
      check({name, ".cnt"},     32'(bus.instr_cnt), 32'(exp_cnt));
      @(posedge clk); #1;
      if (!stalled) idx++;
    end
    if (legal) begin
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check({name, ".back_to_fetch"}, 32'(bus.state),     32'(P_FETCH));
      check({name, ".retired"},       32'(bus.instr_cnt), 32'(exp_cnt));
    end else begin
      check({name, ".enter_trap"}, 32'(bus.state), 32'(P_TRAP));
    end
  endtask

  // Assert reset between edges and check every output drops before the
  // next rising edge; then release and step into the first FETCH.
  task automatic async_reset(input string name);
    #1 rst_n = 1'b0;
    #1;
    check({name, ".state"},    32'(bus.state),     32'(P_IDLE));
    check({name, ".mem_read"}, 32'(bus.mem_read),  32'(0));
    check({name, ".ctrl"},     32'(obs_ctrl()),    32'(0));
    check({name, ".illegal"},  32'(bus.illegal),   32'(0));
    check({name, ".cnt"},      32'(bus.instr_cnt), 32'(0));
    exp_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] legal_ops[7];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03};

    rst_n = 1'b0;
    bus.opcode = '0; bus.jr = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state",   32'(bus.state),     32'(P_IDLE));
    check("reset.ctrl",    32'(obs_ctrl()),    32'(0));
    check("reset.illegal", 32'(bus.illegal),   32'(0));
    check("reset.cnt",     32'(bus.instr_cnt), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 check("idle.ctrl", 32'(obs_ctrl()), 32'(0));
    @(posedge clk); #1;

    // Directed walk through every instruction class
    run_instr("rtype",  6'h00, 1'b0, 0, 0);
    run_instr("lw_st3", 6'h23, 1'b0, 0, 3);
    run_instr("jr",     6'h00, 1'b1, 0, 0);
    run_instr("beq",    6'h04, 1'b0, 0, 0);
    run_instr("sw",     6'h2B, 1'b0, 0, 0);
    run_instr("jal",    6'h03, 1'b0, 0, 0);
    run_instr("addi",   6'h08, 1'b0, 1, 0);
    run_instr("j",      6'h02, 1'b0, 0, 0);
    run_instr("sw_st2", 6'h2B, 1'b0, 2, 2);

    // Random mix with random stalls; enough to wrap the counter
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op = legal_ops[$urandom_range(6)];
      run_instr("rand", op, 1'($urandom), int'($urandom_range(2)),
                int'($urandom_range(3)));
    end

    // Reset mid-FETCH with a pending fetch and a non-zero count
    bus.mem_ready = 1'b0;
    #1 check("midfetch.mem_read", 32'(bus.mem_read), 32'(1));
    async_reset("rst_fetch");

    run_instr("post_rst", 6'h00, 1'b0, 0, 0);
    run_instr("illegal",  6'h3F, 1'b0, 1, 0);
    for (int c = 0; c < 25; c++) begin
      bus.opcode    = 6'($urandom);
      bus.jr        = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      #1;
      check("trap.state",   32'(bus.state),     32'(P_TRAP));
      check("trap.illegal", 32'(bus.illegal),   32'(1));
      check("trap.ctrl",    32'(obs_ctrl()),    32'(0));
      check("trap.cnt",     32'(bus.instr_cnt), 32'(exp_cnt));
      @(posedge clk); #1;
    end
    async_reset("rst_trap");
    run_instr("after_trap", 6'h23, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sits directly upstream of the ALU control decoder.
- Consumes the IR opcode field and the decoder's jr flag.
- Produces alu_op[1:0] plus all datapath/memory enables, sequencing one instruction over 3-5 cycles with a memory-ready handshake.
- Counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
jr  input  1  from ALU control decoder; valid while alu_op==2'b10
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU equal flag set (gated externally)
pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
i_or_d  output  1  0 instruction address (PC), 1 data address (ALUOut)
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
reg_dst  output  2  00 rt, 01 rd, 10 r31
reg_write  output  1  register file write
alu_src_a  output  1  0 PC, 1 A
alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  output  2  00 add, 01 compare-equal, 10 use funct
illegal  output  1  sticky illegal-opcode flag
instr_cnt  output  CNT_W  retired instruction count
state  output  4  current state (debug)

Behaviour:
- Clock and reset: one clock domain; rst_n asynchronous active-low. Reset forces state=IDLE, illegal=0, instr_cnt=0.
- Outputs are Moore, decoded from the state register only. Exception: ir_write and pc_write in FETCH are additionally qualified by mem_ready.
- All outputs are 0 in IDLE and TRAP, and 0 in any state unless listed below.
- IDLE (0): next state FETCH.
- FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready, pc_src=00. Stay while !mem_ready; else DECODE.
- DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x08 → ADDI_EX
  - 0x02 → JUMP
  - 0x03 → JAL
  - else → TRAP
- MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEM_RD; sw → MEM_WR.
- MEM_RD (4): mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB (5): reg_write=1, mem_to_reg=01, reg_dst=00. Next FETCH.
- MEM_WR (6): mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10. jr=1 → JR, else ALU_WB.
- ALU_WB (8): reg_write=1, reg_dst=01, mem_to_reg=00. Next FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Next FETCH.
- JUMP (10): pc_write=1, pc_src=10. Next FETCH.
- ADDI_EX (11): alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB (12): reg_write=1, reg_dst=00, mem_to_reg=00. Next FETCH.
- JR (13): pc_write=1, pc_src=11; no reg_write. Next FETCH.
- JAL (14): pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. PC already holds PC+4, and the register file samples the old PC on the same edge as the PC update. Next FETCH.
- TRAP (15): illegal=1 (sticky). Remain in TRAP until reset.
- Latency in cycles, with mem_ready always 1:
  - R-type 4, addi 4, sw 4, lw 5
  - beq 3, j 3, jr 4, jal 3
  - Each cycle mem_ready is low in a memory state adds exactly one cycle.
- instr_cnt increments by 1 on each transition into FETCH from any state other than IDLE. It wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. A pending memory access is abandoned; mem_read/mem_write drop asynchronously.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

Decomposition:
- Shared define.v (alongside the existing ALU-op and funct constants) holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL;
  - 4-bit state encodings S_IDLE..S_TRAP;
  - pc_src, mem_to_reg and reg_dst select encodings.
- One natural sub-module: mips_mc_outdec, a purely combinational state-to-control-word decoder. The FSM keeps the state register, next-state logic, counter and trap flag.

Test Plan:
- Reset, R-type add (opcode 0x00), jr=0, mem_ready=1 → state sequence 0,1,2,7,8,1. alu_op=10 in EXEC; reg_write=1 with reg_dst=01 for exactly one cycle; instr_cnt=1.
- lw (0x23), mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles with mem_read=1, i_or_d=1. One MEM_WB cycle with mem_to_reg=01; total 8 cycles; instr_cnt+1.
- R-type with jr=1 during EXEC → JR state: pc_write=1, pc_src=11, reg_write=0 for all cycles; back to FETCH.
- beq (0x04), then sw (0x2B) → BRANCH: alu_op=01, pc_write_cond=1, pc_src=01. sw: mem_write=1 in MEM_WR, 4 cycles total; instr_cnt +2.
- jal (0x03) → JAL cycle: pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 simultaneously.
- Opcode 0x3F → TRAP with illegal=1 held 20+ cycles, instr_cnt unchanged. Then rst_n low mid-FETCH with mem_ready=0 → state=0, mem_read=0, illegal=0, instr_cnt=0 before the next clk edge.
